dot_accumulator: RTL

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

---
 rtl/dot_accumulator_pkg.sv | 18 +
 rtl/dot_accumulator_sat_clamp.sv | 29 ++
 rtl/dot_accumulator.sv | 84 ++++++++
 3 files changed

// File: rtl/dot_accumulator_pkg.sv
// Shared defaults, state encoding and accumulator sizing for the dot-product accumulator.
package dot_accumulator_pkg;

  localparam int N_DEF      = 32;
  localparam int K_DEF      = 8;
  localparam int GUARD_BITS = 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Wide enough that K terms of 2N-bit signed products can never wrap.
  function automatic int acc_width(input int n, input int k);
    return 2 * n + $clog2(k) + GUARD_BITS;
  endfunction

endpackage

// File: rtl/dot_accumulator_sat_clamp.sv
// Combinational signed saturation of a W-bit value down to the 2N-bit signed range.
module sat_clamp #(
  parameter int N = 32,
  parameter int W = 67
) (
  input  logic [W-1:0]   wide,
  output logic [2*N-1:0] value,
  output logic           ovf
);

  localparam int PW = 2 * N;

  logic [W-PW:0] top_bits;
  logic          fits;

  // The value fits when every bit from the product sign bit upward matches.
  assign top_bits = wide[W-1:PW-1];
  assign fits     = (top_bits == '0) || (top_bits == '1);

  always_comb begin
    value = wide[PW-1:0];
    ovf   = 1'b0;
    if (!fits) begin
      ovf   = 1'b1;
      value = wide[W-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates up to K signed 2N-bit products and holds a saturated result until consumed.
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N-1:0]         in_p,
  input  logic                   in_last,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_sum,
  output logic                   out_ovf,
  output logic [$clog2(K+1)-1:0] out_cnt
);

  localparam int PW    = 2 * N;
  localparam int ACC_W = acc_width(N, K);
  localparam int CW    = $clog2(K + 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [PW-1:0]    sat_value;
  logic             sat_ovf;

  assign acc_next  = acc + {{(ACC_W-PW){in_p[PW-1]}}, in_p};
  assign cnt_next  = cnt + 1'b1;
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  sat_clamp #(.N(N), .W(ACC_W)) u_sat (
    .wide  (acc_next),
    .value (sat_value),
    .ovf   (sat_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_cnt <= '0;
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt_next;
            // The final term is captured straight from the adder so the result lands one cycle later.
            if (in_last || cnt_next == CW'(K)) begin
              state   <= HOLD;
              out_sum <= sat_value;
              out_ovf <= sat_ovf;
              out_cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
